// File: rtl/mem_test_initiator.sv
// mem_test_initiator: memory port traffic generator and checker.
// Writes p_num_reqs full-width words, reads them back, checks each response
// for type, opaque and (on reads) data, then reports pass/fail.
// Optional build macro MEM_TEST_INIT_RAND_STALL_EN adds LFSR-driven stalls
// on the request and response handshakes.
module mem_test_initiator #(
    parameter int          p_opaque_nbits    = 8,
    parameter int          p_addr_nbits      = 32,
    parameter int          p_data_nbits      = 32,
    parameter int          p_num_reqs        = 16,
    parameter int          p_base_addr       = 0,
    parameter int          p_max_outstanding = 4,
    parameter logic [31:0] p_data_seed       = 32'hA5A5_0000,
    localparam int LEN_NBITS  = (p_data_nbits > 8) ? $clog2(p_data_nbits / 8) : 1,
    localparam int REQ_NBITS  = 3 + p_opaque_nbits + p_addr_nbits + LEN_NBITS + p_data_nbits,
    localparam int RESP_NBITS = 3 + p_opaque_nbits + LEN_NBITS + p_data_nbits
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  memreq_val,
    input  logic                  memreq_rdy,
    output logic [REQ_NBITS-1:0]  memreq_msg,
    input  logic                  memresp_val,
    output logic                  memresp_rdy,
    input  logic [RESP_NBITS-1:0] memresp_msg,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count
);

    localparam logic [2:0] TYPE_READ  = 3'd0;
    localparam logic [2:0] TYPE_WRITE = 3'd1;
    localparam int CNT_NBITS = $clog2(p_num_reqs + 1);
    localparam int SUM_NBITS = (p_data_nbits > 32) ? p_data_nbits : 32;
    localparam logic [CNT_NBITS-1:0] NUM_REQS = CNT_NBITS'(p_num_reqs);
    localparam logic [CNT_NBITS-1:0] LAST_IDX = CNT_NBITS'(p_num_reqs - 1);
    localparam logic [3:0]           MAX_OUT  = 4'(p_max_outstanding);

    typedef enum logic [2:0] {
        IDLE,
        WR,
        WR_DRAIN,
        RD,
        RD_DRAIN,
        DONE
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_NBITS-1:0]   req_idx;
    logic [CNT_NBITS-1:0]   resp_idx;
    logic [3:0]             outstanding;
    logic [3:0]             outstanding_next;
    logic [15:0]            err_next;
    logic                   req_fire;
    logic                   resp_fire;
    logic                   resp_err;
    logic                   req_allowed;
    logic                   wr_phase;
    logic                   last_req;
    logic                   enter_phase;
    logic                   restart;

    logic [p_addr_nbits-1:0]   req_addr;
    logic [p_data_nbits-1:0]   req_data;
    logic [SUM_NBITS-1:0]      req_sum;
    logic [SUM_NBITS-1:0]      exp_sum;
    logic [p_data_nbits-1:0]   exp_data;
    logic [p_opaque_nbits-1:0] exp_opaque;

    logic [2:0]                resp_type;
    logic [p_opaque_nbits-1:0] resp_opaque;
    logic [LEN_NBITS-1:0]      unused_resp_len;
    logic [p_data_nbits-1:0]   resp_data;

    assign resp_type       = memresp_msg[RESP_NBITS-1 -: 3];
    assign resp_opaque     = memresp_msg[LEN_NBITS + p_data_nbits +: p_opaque_nbits];
    assign unused_resp_len = memresp_msg[p_data_nbits +: LEN_NBITS];
    assign resp_data       = memresp_msg[p_data_nbits-1:0];

`ifdef MEM_TEST_INIT_RAND_STALL_EN
    logic [15:0] lfsr;
    logic        val_hold;

    // Free-running Fibonacci LFSR (taps 16,14,13,11) that picks stall cycles
    always_ff @(posedge clk) begin
        if (!reset) begin
            lfsr <= 16'hACE1;
        end else begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end

    // Remember an un-accepted request so the stall gate cannot withdraw it
    always_ff @(posedge clk) begin
        if (!reset) begin
            val_hold <= 1'b0;
        end else begin
            val_hold <= memreq_val && !memreq_rdy;
        end
    end
`endif

    // Handshakes, request fields, response checking and counter arithmetic
    always_comb begin
        wr_phase    = (state == WR) || (state == WR_DRAIN);
        busy        = (state != IDLE) && (state != DONE);
        req_allowed = ((state == WR) || (state == RD)) &&
                      (req_idx < NUM_REQS) && (outstanding < MAX_OUT);
`ifdef MEM_TEST_INIT_RAND_STALL_EN
        memreq_val  = req_allowed && (lfsr[1] || val_hold);
        memresp_rdy = busy && lfsr[0];
`else
        memreq_val  = req_allowed;
        memresp_rdy = busy;
`endif
        req_fire  = memreq_val && memreq_rdy;
        resp_fire = memresp_val && memresp_rdy;
        last_req  = req_fire && (req_idx == LAST_IDX);

        outstanding_next = outstanding;
        if (req_fire && !resp_fire) begin
            outstanding_next = outstanding + 4'd1;
        end else if (!req_fire && resp_fire) begin
            outstanding_next = outstanding - 4'd1;
        end

        req_addr = p_addr_nbits'(p_base_addr) +
                   p_addr_nbits'(req_idx) * p_addr_nbits'(p_data_nbits / 8);
        req_sum  = SUM_NBITS'(p_data_seed) + SUM_NBITS'(req_idx);
        req_data = (state == WR) ? p_data_nbits'(req_sum) : '0;
        memreq_msg = {(state == WR) ? TYPE_WRITE : TYPE_READ,
                      p_opaque_nbits'(req_idx),
                      req_addr,
                      LEN_NBITS'(0),
                      req_data};

        exp_sum    = SUM_NBITS'(p_data_seed) + SUM_NBITS'(resp_idx);
        exp_data   = p_data_nbits'(exp_sum);
        exp_opaque = p_opaque_nbits'(resp_idx);
        resp_err   = resp_fire &&
                     ((resp_type != (wr_phase ? TYPE_WRITE : TYPE_READ)) ||
                      (resp_opaque != exp_opaque) ||
                      (!wr_phase && (resp_data != exp_data)));

        restart  = start && (state == DONE);
        err_next = err_count;
        if (restart) begin
            err_next = 16'd0;
        end else if (resp_err && (err_count != 16'hFFFF)) begin
            err_next = err_count + 16'd1;
        end
    end

    // Phase sequencing: write burst, drain, read burst, drain, report
    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (start) state_next = WR;
            WR:       if (last_req) state_next = (outstanding_next == 4'd0) ? RD : WR_DRAIN;
            WR_DRAIN: if (outstanding_next == 4'd0) state_next = RD;
            RD:       if (last_req) state_next = (outstanding_next == 4'd0) ? DONE : RD_DRAIN;
            RD_DRAIN: if (outstanding_next == 4'd0) state_next = DONE;
            DONE:     if (start) state_next = WR;
            default:  state_next = IDLE;
        endcase
        enter_phase = ((state_next == WR) || (state_next == RD)) && (state_next != state);
    end

    // State register, per-phase indices, outstanding count and run result
    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            req_idx     <= '0;
            resp_idx    <= '0;
            outstanding <= 4'd0;
            err_count   <= 16'd0;
            done        <= 1'b0;
            pass        <= 1'b0;
        end else begin
            state       <= state_next;
            outstanding <= outstanding_next;
            err_count   <= err_next;
            if (enter_phase) begin
                req_idx  <= '0;
                resp_idx <= '0;
            end else begin
                if (req_fire) req_idx <= req_idx + CNT_NBITS'(1);
                if (resp_fire) resp_idx <= resp_idx + CNT_NBITS'(1);
            end
            if (restart) begin
                done <= 1'b0;
                pass <= 1'b0;
            end else if ((state_next == DONE) && (state != DONE)) begin
                done <= 1'b1;
                pass <= (err_next == 16'd0);
            end
        end
    end

endmodule

// File: tb/tb_mem_test_initiator.sv
// tb_mem_test_initiator: drives mem_test_initiator against a behavioural
// word memory with configurable latency, stalls and response corruption.
module tb_mem_test_initiator;

    localparam int O      = 8;
    localparam int A      = 32;
    localparam int D      = 32;
    localparam int LW     = 2;
    localparam int N      = 16;
    localparam int MAXOUT = 4;
    localparam int REQ_W  = 3 + O + A + LW + D;
    localparam int RESP_W = 3 + O + LW + D;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              memreq_val;
    logic              memreq_rdy = 1'b0;
    logic [REQ_W-1:0]  memreq_msg;
    logic              memresp_val = 1'b0;
    logic              memresp_rdy;
    logic [RESP_W-1:0] memresp_msg = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [15:0]       err_count;

    mem_test_initiator #(
        .p_opaque_nbits   (O),
        .p_addr_nbits     (A),
        .p_data_nbits     (D),
        .p_num_reqs       (N),
        .p_base_addr      (0),
        .p_max_outstanding(MAXOUT),
        .p_data_seed      (SEED)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .memreq_val (memreq_val),
        .memreq_rdy (memreq_rdy),
        .memreq_msg (memreq_msg),
        .memresp_val(memresp_val),
        .memresp_rdy(memresp_rdy),
        .memresp_msg(memresp_msg),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count)
    );

    // 10 ns clock
    always #5 clk = ~clk;

    // Hard stop in case something wedges outside a bounded wait
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int checks = 0;
    int failures = 0;

    logic [D-1:0]      mem [0:63];
    logic [RESP_W-1:0] resp_q[$];
    int                resp_due_q[$];
    bit                resp_wr_q[$];

    int cyc = 0;
    int run_cycle = 0;
    int stall_mode = 0;
    int lat_min = 1;
    int lat_max = 1;
    bit no_resp = 1'b0;
    int win_start = 0;
    int win_len = 0;
    int bad_rd_data = -1;
    int bad_wr_opaque = -1;
    int bad_rd_type = -1;
    int wr_fired = 0;
    int rd_fired = 0;
    int wr_acc = 0;
    int rd_acc = 0;
    bit start_pending = 1'b0;
    bit prev_stalled = 1'b0;
    logic [REQ_W-1:0] prev_msg = '0;

    task automatic checkOutput(input string tag, input logic [127:0] actual, input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    // Request k of a phase as the initiator should present it
    function automatic logic [REQ_W-1:0] expReq(input bit is_wr, input int k);
        logic [31:0] addr;
        logic [31:0] data;
        addr = 32'(k * 4);
        data = is_wr ? SEED + 32'(k) : 32'd0;
        return {is_wr ? 3'd1 : 3'd0, 8'(k), addr, 2'd0, data};
    endfunction

    // Memory side of one accepted request: update the store, queue the response
    task automatic serveReq();
        bit          exp_wr;
        int          k;
        logic [2:0]  r_type;
        logic [7:0]  r_opq;
        logic [31:0] r_addr;
        logic [31:0] r_data;
        exp_wr = (wr_fired < N);
        k = exp_wr ? wr_fired : rd_fired;
        if (!exp_wr && rd_fired >= N) checkOutput("req_overflow", rd_fired, N - 1);
        checkOutput(exp_wr ? "wr_req_msg" : "rd_req_msg", memreq_msg, expReq(exp_wr, k));
        if (!exp_wr && rd_fired == 0) checkOutput("rd_after_wr_resps", wr_acc, N);
        r_type = memreq_msg[REQ_W-1 -: 3];
        r_opq  = memreq_msg[REQ_W-4 -: 8];
        r_addr = memreq_msg[D + LW +: A];
        if (r_type == 3'd1) begin
            mem[r_addr[7:2]] = memreq_msg[D-1:0];
            r_data = $urandom;
            if (k == bad_wr_opaque) r_opq = r_opq ^ 8'h40;
        end else begin
            r_data = mem[r_addr[7:2]];
            if (k == bad_rd_data) r_data = r_data ^ 32'h1;
            if (k == bad_rd_type) r_type = 3'd1;
        end
        resp_q.push_back({r_type, r_opq, 2'd0, r_data});
        resp_due_q.push_back(cyc + $urandom_range(lat_max, lat_min));
        resp_wr_q.push_back(exp_wr);
        if (exp_wr) wr_fired++; else rd_fired++;
    endtask

    // One clock of memory behaviour: drive inputs on the falling edge, then
    // record which handshakes will fire on the next rising edge
    task automatic applyStimulus();
        @(negedge clk);
        cyc++;
        run_cycle++;
        start = start_pending;
        start_pending = 1'b0;
        if (prev_stalled) begin
            checkOutput("req_hold_val", memreq_val, 1'b1);
            checkOutput("req_hold_msg", memreq_msg, prev_msg);
        end
        case (stall_mode)
            1:       memreq_rdy = !(run_cycle >= win_start && run_cycle < win_start + win_len);
            2:       memreq_rdy = ($urandom_range(3, 0) != 0);
            default: memreq_rdy = 1'b1;
        endcase
        if (!no_resp && resp_q.size() > 0 && resp_due_q[0] <= cyc &&
            (stall_mode != 2 || $urandom_range(3, 0) != 0)) begin
            memresp_val = 1'b1;
            memresp_msg = resp_q[0];
        end else begin
            memresp_val = 1'b0;
            memresp_msg = RESP_W'({$urandom, $urandom});
        end
        #1;
        if (memreq_val && memreq_rdy) serveReq();
        if (memresp_val && memresp_rdy) begin
            if (resp_wr_q[0]) wr_acc++; else rd_acc++;
            void'(resp_q.pop_front());
            void'(resp_due_q.pop_front());
            void'(resp_wr_q.pop_front());
        end
        prev_stalled = memreq_val && !memreq_rdy;
        prev_msg = memreq_msg;
    endtask

    task automatic configure(input int s_mode, input int l_min, input int l_max,
                             input int c_rd_data, input int c_wr_opq, input int c_rd_type);
        stall_mode    = s_mode;
        lat_min       = l_min;
        lat_max       = l_max;
        bad_rd_data   = c_rd_data;
        bad_wr_opaque = c_wr_opq;
        bad_rd_type   = c_rd_type;
        no_resp       = 1'b0;
    endtask

    task automatic clearEnv();
        resp_q.delete();
        resp_due_q.delete();
        resp_wr_q.delete();
        wr_fired = 0;
        rd_fired = 0;
        wr_acc = 0;
        rd_acc = 0;
        prev_stalled = 1'b0;
    endtask

    // Pulse start and step past the edge that samples it
    task automatic startRun();
        clearEnv();
        run_cycle = 0;
        start_pending = 1'b1;
        applyStimulus();
        applyStimulus();
    endtask

    task automatic finishRun(input string tag, input int exp_errs, input int max_lat);
        int n;
        n = 0;
        while (!done && n < 600) begin
            applyStimulus();
            n++;
        end
        checkOutput({tag, "_done"}, done, 1'b1);
        checkOutput({tag, "_pass"}, pass, exp_errs == 0);
        checkOutput({tag, "_err_count"}, err_count, exp_errs);
        checkOutput({tag, "_writes"}, wr_fired, N);
        checkOutput({tag, "_reads"}, rd_fired, N);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        if (max_lat > 0) checkOutput({tag, "_latency_ok"}, (run_cycle - 2) <= max_lat, 1'b1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_req_val"}, memreq_val, 1'b0);
        checkOutput({tag, "_resp_rdy"}, memresp_rdy, 1'b0);
        checkOutput({tag, "_busy"}, busy, 1'b0);
        checkOutput({tag, "_done"}, done, 1'b0);
        checkOutput({tag, "_pass"}, pass, 1'b0);
        checkOutput({tag, "_err"}, err_count, 16'd0);
    endtask

    // Scenario sequence
    initial begin
        int n;
        int bad;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        configure(0, 1, 1, -1, -1, -1);
        reset = 1'b0;
        applyStimulus();
        applyStimulus();
        checkResetValues("reset");
        reset = 1'b1;
        applyStimulus();
        checkResetValues("idle");

        $display("[TB] clean run, always ready, one-cycle memory");
        startRun();
        checkOutput("first_req_val", memreq_val, 1'b1);
        finishRun("clean", 0, 36);
        for (int i = 0; i < 3; i++) applyStimulus();
        checkOutput("done_held", done, 1'b1);
        checkOutput("pass_held", pass, 1'b1);
        checkOutput("done_resp_rdy", memresp_rdy, 1'b0);

        $display("[TB] ten-cycle request stall during writes");
        configure(1, 1, 1, -1, -1, -1);
        win_start = 4;
        win_len = 10;
        startRun();
        finishRun("stall", 0, 0);

        $display("[TB] random stalls and latency, stray start mid-run");
        configure(2, 1, 4, -1, -1, -1);
        startRun();
        for (int i = 0; i < 8; i++) applyStimulus();
        start_pending = 1'b1;
        finishRun("random", 0, 0);

        $display("[TB] corrupted read data at index 5");
        configure(0, 1, 2, 5, -1, -1);
        startRun();
        finishRun("bad_rd_data", 1, 0);

        $display("[TB] wrong opaque on write 3, wrong type on read 7");
        configure(2, 1, 3, -1, 3, 7);
        startRun();
        finishRun("bad_opq_type", 2, 0);

        for (int r = 0; r < 2; r++) begin
            bad = $urandom_range(N - 1, 0);
            $display("[TB] random run %0d corrupting read %0d", r, bad);
            configure(2, 1, 4, bad, -1, -1);
            startRun();
            finishRun("rand_corrupt", 1, 0);
        end

        $display("[TB] memory that never responds");
        configure(0, 1, 1, -1, -1, -1);
        no_resp = 1'b1;
        startRun();
        for (int i = 0; i < 30; i++) applyStimulus();
        checkOutput("noresp_fired", wr_fired, MAXOUT);
        checkOutput("noresp_val", memreq_val, 1'b0);
        checkOutput("noresp_busy", busy, 1'b1);
        checkOutput("noresp_done", done, 1'b0);
        reset = 1'b0;
        prev_stalled = 1'b0;
        applyStimulus();
        checkResetValues("noresp_reset");
        reset = 1'b1;
        clearEnv();
        applyStimulus();

        $display("[TB] reset asserted during the read phase");
        configure(0, 1, 1, -1, -1, -1);
        startRun();
        n = 0;
        while (rd_fired < 3 && n < 200) begin
            applyStimulus();
            n++;
        end
        checkOutput("reached_rd_phase", rd_fired >= 3, 1'b1);
        reset = 1'b0;
        prev_stalled = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus();
            checkResetValues("rd_reset");
        end
        reset = 1'b1;
        clearEnv();
        applyStimulus();
        startRun();
        finishRun("after_reset", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_test_initiator.md
Name: mem_test_initiator

Overview:
Memory request initiator (traffic generator plus checker). It drives the requester side of the codebase's val/rdy memory req/resp message interface, i.e. the port a test memory or cache serves. On start it issues a burst of full-width writes, then reads the same addresses back. It checks every response for type, opaque and data, and reports pass/fail. It is used to self-test memory ports and cache datapaths without a processor.

Parameters:
p_opaque_nbits, 8, opaque field width (o)
p_addr_nbits, 32, address field width (a)
p_data_nbits, 32, data field width (d); multiple of 8
p_num_reqs, 16, writes per run and reads per run; 1..2^o
p_base_addr, 0, byte address of the first access
p_max_outstanding, 4, cap on requests sent with no response yet; 1..15
p_data_seed, 32'hA5A5_0000, base of the write-data pattern

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (asserted when 0)
start  in  1  pulse; begins a run when in IDLE or DONE
memreq_val  out  1  request valid
memreq_rdy  in  1  request ready
memreq_msg  out  VC_MEM_REQ_MSG_NBITS(o,a,d)  request {type,opaque,addr,len,data}
memresp_val  in  1  response valid
memresp_rdy  out  1  response ready
memresp_msg  in  VC_MEM_RESP_MSG_NBITS(o,d)  response {type,opaque,len,data}
busy  out  1  run in progress
done  out  1  run complete; held until the next start or reset
pass  out  1  valid when done=1; 1 if err_count==0
err_count  out  16  number of mismatching responses, saturating at 16'hFFFF

Behaviour:
- One clock. Reset is synchronous and active-low: reset==0 sampled at posedge clk resets the block.
- Reset values: state=IDLE, memreq_val=0, memresp_rdy=0, busy=0, done=0, pass=0, err_count=0, all counters 0.
- FSM:
  - IDLE: start moves to WR.
  - WR: issues writes. Moves to WR_DRAIN once p_num_reqs writes are sent.
  - WR_DRAIN: moves to RD when the outstanding count reaches 0.
  - RD: issues reads. Moves to RD_DRAIN once p_num_reqs reads are sent.
  - RD_DRAIN: moves to DONE when the outstanding count reaches 0.
  - DONE: start moves to WR, clearing err_count, done and pass on the same edge.
  - start in any other state is ignored.
- Request index i runs 0..p_num_reqs-1 in each phase.
- Request fields:
  - addr = p_base_addr + i*(d/8), truncated to a bits.
  - len = 0 (full width).
  - opaque = i[o-1:0].
  - type = VC_MEM_REQ_MSG_TYPE_WRITE in WR, VC_MEM_REQ_MSG_TYPE_READ in RD.
  - data = (p_data_seed + i) in WR, truncated or zero-extended to d; data = 0 in RD.
- memreq_val: 1 in WR/RD while fewer than p_num_reqs requests are sent in the phase and outstanding < p_max_outstanding. It depends only on registered state, with no combinational path from memreq_rdy.
- Once memreq_val=1, memreq_msg is held stable until memreq_rdy=1 (fire). Fire increments i and outstanding.
- memresp_rdy: 1 in WR, WR_DRAIN, RD and RD_DRAIN; 0 in IDLE and DONE.
- A response fire decrements outstanding. Request fire and response fire in the same cycle leave outstanding unchanged.
- Responses are checked in order against a per-phase expected index e. Each fire increments e.
- A response is an error if:
  - type differs from the phase type, or
  - opaque != e[o-1:0], or
  - in RD only, data != (p_data_seed + e) truncated to d.
  - Write-response data is ignored.
- Each error increments err_count by 1, saturating.
- A response arriving in IDLE/DONE is not accepted (rdy=0).
- busy = state in {WR, WR_DRAIN, RD, RD_DRAIN}.
- done is set on entry to DONE, with pass = (err_count==0 after the final check).
- Reset mid-run abandons the run immediately and returns all state to reset values. Any responses still in flight belong to the environment.
- Latency:
  - First request valid the cycle after start is sampled.
  - With zero-latency memory and rdy held high, one request fires per cycle.
  - The RD phase begins the cycle after the last write response.

Optional Feature:
- Macro: MEM_TEST_INIT_RAND_STALL_EN.
- When defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1, loaded on reset) advances every cycle.
  - memresp_rdy is additionally gated low when lfsr[0]==0.
  - memreq_val is additionally gated low when lfsr[1]==0.
  - Gating applies only at the start of a valid cycle; once asserted, val stays high until fire.
- When undefined: no LFSR, no gating; behaviour is exactly as above.

Test Plan:
- Zero-latency memory, rdy always 1, p_num_reqs=16, start pulse -> 16 writes to 0x00..0x3C with data 0xA5A50000..0xA5A5000F, then 16 reads; done=1, pass=1, err_count=0 by cycle 36 or earlier.
- Memory with memreq_rdy=0 for 10 cycles during WR -> memreq_msg held constant throughout; no request lost; pass=1.
- Memory returning no responses, p_max_outstanding=4 -> exactly 4 requests fire, then memreq_val=0 and the block stays in WR.
- Memory corrupts the data of read index 5 -> err_count=1, pass=0 at done.
- Memory returns wrong opaque on write 3 and wrong type on read 7 -> err_count=2.
- reset=0 asserted during RD, then released and start pulsed -> all outputs at reset values while asserted; a full clean second run ends with pass=1, err_count=0.
